// File: rtl/imem_uart_loader_pkg.sv
// Shared constants for the UART boot loader: header byte, loader FSM and
// RX FSM encodings, and a small state classifier.
package imem_uart_loader_pkg;

  localparam logic [7:0] LDR_HDR = 8'hA5;

  // Loader FSM encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // UART receiver encodings
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // States in which a framing error aborts the image
  function automatic logic is_loading(input logic [2:0] s);
    return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect with a
// mid-bit re-check, LSB-first data, mid-bit stop sample.
module uart_rx_8n1
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  assign rx_byte_o    = byte_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = ferr_q;

  // Next-state: bit timing counter, shift register and one-cycle result pulses
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    byte_d = byte_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) st_d = RX_START;
      end
      RX_START: begin
        // A start bit must still be low at its midpoint; shorter lows are glitches
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_sync_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (rx_sync_q) begin
            vld_d  = 1'b1;
            byte_d = sh_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // State registers; the line idles high so the synchroniser resets to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      st_q      <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      byte_q    <= byte_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives A5,N,2N data bytes (hi first),XOR checksum over UART,
// writes 16-bit words into instruction RAM and releases the core on success.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_i,
  output logic          cpu_reset_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [15:0]   imem_wd_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW:0]   words_o
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (rx_ferr)
  );

  logic [2:0]    state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   words_q, words_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    xor_q, xor_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wd_q, wd_d;

  logic [AW:0] words_inc;
  logic        n_bad;

  assign words_inc = words_q + (AW+1)'(1);
  assign n_bad     = (rx_byte == 8'd0) || ({24'd0, rx_byte} > 32'(DEPTH));

  assign cpu_reset_o = (state_q != S_RUN);
  assign done_o      = (state_q == S_RUN);
  assign err_o       = (state_q == S_ERR);
  assign imem_we_o   = we_q;
  assign imem_addr_o = addr_q;
  assign imem_wd_o   = wd_q;
  assign words_o     = words_q;

  // Loader FSM; every transition is driven by a received byte or framing error
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    hi_d    = hi_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    if (rx_ferr && is_loading(state_q)) begin
      state_d = S_ERR;
    end else if (rx_vld) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (rx_byte == LDR_HDR) begin
            state_d = S_COUNT;
            words_d = '0;
            xor_d   = '0;
          end
        end
        S_COUNT: begin
          if (n_bad) begin
            state_d = S_ERR;
          end else begin
            n_d     = (AW+1)'(rx_byte);
            state_d = S_HI;
          end
        end
        S_HI: begin
          hi_d    = rx_byte;
          xor_d   = xor_q ^ rx_byte;
          state_d = S_LO;
        end
        S_LO: begin
          // Write lands one cycle after the low byte; words stops at N
          we_d    = 1'b1;
          wd_d    = {hi_q, rx_byte};
          addr_d  = words_q[AW-1:0];
          words_d = words_inc;
          xor_d   = xor_q ^ rx_byte;
          state_d = (words_inc == n_q) ? S_CSUM : S_HI;
        end
        S_CSUM: state_d = (rx_byte == xor_q) ? S_RUN : S_ERR;
        default: ;
      endcase
    end
  end

  // Loader registers; RUN is terminal until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      words_q <= '0;
      hi_q    <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      hi_q    <= hi_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader at 16 clocks per bit: table of frames plus
// hand-written corner sequences; RAM writes checked against a queue.
module tb_imem_uart_loader;

  localparam int AW = 6;
  localparam int BT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          cpu_reset, imem_we, done, err;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wd;
  logic [AW:0]   words;

  imem_uart_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .DEPTH(64), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx),
    .cpu_reset_o (cpu_reset),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wd_o   (imem_wd),
    .done_o      (done),
    .err_o       (err),
    .words_o     (words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ev_cnt = 0;
  int we_cnt = 0;
  logic bv_prev = 1'b0;

  typedef struct { logic [AW-1:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: each write pulse must match the next expected write and
  // follow a received byte by exactly one cycle
  always @(negedge clk) begin
    if (dut.u_rx.byte_valid_o || dut.u_rx.frame_err_o) ev_cnt++;
    if (imem_we) begin
      wr_t w;
      we_cnt++;
      chk("we_latency", 32'(bv_prev), 32'd1);
      chk("we_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("we_addr", 32'(imem_addr), 32'(w.a));
        chk("we_data", 32'(imem_wd), 32'(w.d));
      end
    end
    bv_prev = dut.u_rx.byte_valid_o;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BT) @(negedge clk);
    end
    rx = stop;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
  endtask

  task automatic push_wr(input int a, input logic [15:0] d);
    wr_t w;
    w.a = AW'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic chk_status(input string nm, input logic d, input logic e,
                            input logic c, input int w);
    chk({nm, "_done"}, 32'(done), 32'(d));
    chk({nm, "_err"}, 32'(err), 32'(e));
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    chk({nm, "_words"}, 32'(words), 32'(w));
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    string       name;
    bit          rst;
    int          nb;
    logic [63:0] b;
    int          nwr;
    logic [31:0] wr;
    logic        d, e, c;
    int          w;
  } vec_t;

  function automatic vec_t mk(string n, bit rst, int nb, logic [63:0] b, int nwr,
                              logic [31:0] wr, logic d, logic e, logic c, int w);
    vec_t v;
    v.name = n; v.rst = rst; v.nb = nb; v.b = b; v.nwr = nwr; v.wr = wr;
    v.d = d; v.e = e; v.c = c; v.w = w;
    return v;
  endfunction

  initial begin
    #(10 * 90_000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    logic [7:0] x, hi, lo;
    int we0, ev0;

    // Checksum is the XOR of the data bytes: E0^C9^E0^87 = 4E, 12^34 = 26
    vecs[0] = mk("valid",     0, 7, 64'hA5_02_E0C9_E087_4E_00, 2, 32'hE0C9_E087, 1, 0, 0, 2);
    vecs[1] = mk("bad_csum",  1, 7, 64'hA5_02_E0C9_E087_00_00, 2, 32'hE0C9_E087, 0, 1, 1, 2);
    vecs[2] = mk("retry",     0, 7, 64'hA5_02_E0C9_E087_4E_00, 2, 32'hE0C9_E087, 1, 0, 0, 2);
    vecs[3] = mk("n_zero",    1, 2, 64'hA5_00_000000000000,    0, 32'h0,         0, 1, 1, 0);
    vecs[4] = mk("n_over",    0, 2, 64'hA5_41_000000000000,    0, 32'h0,         0, 1, 1, 0);
    vecs[5] = mk("junk",      1, 8, 64'h12_34_56_A5_01_1234_26, 1, 32'h1234_0000, 1, 0, 0, 1);
    vecs[6] = mk("run_ignore",0, 5, 64'hA5_01_ABCD_66_000000, 0, 32'h0,         1, 0, 0, 1);

    // Reset state, then a long idle line with no writes
    repeat (4) @(negedge clk);
    reset = 1'b0;
    we0 = we_cnt;
    repeat (2000) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wd", 32'(imem_wd), 32'd0);
    chk("idle_no_we", 32'(we_cnt - we0), 32'd0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      for (int i = 0; i < vecs[v].nwr; i++) push_wr(i, vecs[v].wr[31 - 16*i -: 16]);
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[63 - 8*i -: 8], 1'b1);
      repeat (20) @(negedge clk);
      chk_status(vecs[v].name, vecs[v].d, vecs[v].e, vecs[v].c, vecs[v].w);
    end

    // Largest legal image: N == DEPTH fills indices 0..63
    do_reset();
    x = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h40, 1'b1);
    for (int i = 0; i < 64; i++) begin
      hi = 8'(i) ^ 8'h5A;
      lo = 8'(i * 3 + 1);
      x = x ^ hi ^ lo;
      push_wr(i, {hi, lo});
      send_byte(hi, 1'b1);
      send_byte(lo, 1'b1);
    end
    send_byte(x, 1'b1);
    repeat (20) @(negedge clk);
    chk_status("n_depth", 1, 0, 0, 64);

    // Stop bit low on the low byte of the first word aborts with no write
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'hC9, 1'b0);
    repeat (20) @(negedge clk);
    chk_status("stop_err", 0, 1, 1, 0);

    // 8-clock low glitch on an idle line produces no byte event
    do_reset();
    repeat (10) @(negedge clk);
    ev0 = ev_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_event", 32'(ev_cnt - ev0), 32'd0);
    chk("glitch_cpu_reset", 32'(cpu_reset), 32'd1);

    // Reset mid-frame returns to idle; a fresh valid frame then loads
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hE0, 1'b1);
    do_reset();
    repeat (5) @(negedge clk);
    chk_status("mid_reset", 0, 0, 1, 0);
    push_wr(0, 16'hE0C9);
    push_wr(1, 16'hE087);
    for (int i = 0; i < 7; i++) begin
      logic [55:0] fr;
      fr = 56'hA5_02_E0C9_E087_4E;
      send_byte(fr[55 - 8*i -: 8], 1'b1);
    end
    repeat (20) @(negedge clk);
    chk_status("after_reset", 1, 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
